// File: rtl/strip_trig_pkg.sv
// Shared definitions for the band trigger scheduler: FSM state encoding,
// default field widths and the slot in which an issue decision is taken.
package strip_trig_pkg;

    localparam int BCID_W_DEF = 12;
    localparam int BAND_W_DEF = 8;
    localparam int DROP_W     = 8;

    // The issue decision is made in the last slot of a BC; the strobe lands in slot 0.
    localparam logic [1:0] ISSUE_SLOT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ISSUE = 2'd2
    } bts_state_t;

endpackage

// File: rtl/sync_cand_fifo.sv
// Candidate FIFO: circular storage, read/write pointers and an occupancy count.
// Flush empties it; a push into a full FIFO is only taken together with a pop.
module sync_cand_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/band_trigger_scheduler.sv
// Band trigger scheduler: queues trigger candidates and issues one per BC on the
// 4x fabric clock. Optional duplicate suppression is enabled with `define BTS_DEDUP_EN.
module band_trigger_scheduler
    import strip_trig_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int BCID_W = BCID_W_DEF,
    parameter int BAND_W = BAND_W_DEF,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cand_valid,
    input  logic [BAND_W-1:0] cand_band_id,
    input  logic [BCID_W-1:0] cand_bcid,
    input  logic              gen_ready,
    input  logic              flush,
    output logic              load_out,
    output logic [BAND_W-1:0] band_id_out,
    output logic [BCID_W-1:0] bcid_out,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [DROP_W-1:0] drop_cnt
);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + DROP_W'(1);
    endfunction

    bts_state_t        state;
    logic [1:0]        slot;
    logic              load_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic              remain;
    logic              dup;
    logic [BAND_W-1:0] head_band;
    logic [BCID_W-1:0] head_bcid;

    sync_cand_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BAND_W + BCID_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push_ok),
        .pop     (pop),
        .wdata   ({cand_band_id, cand_bcid}),
        .rdata   ({head_band, head_bcid}),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

`ifdef BTS_DEDUP_EN
    logic              last_vld;
    logic [BAND_W-1:0] last_band;
    logic [BCID_W-1:0] last_bcid;

    assign dup = cand_valid && last_vld &&
                 (cand_band_id == last_band) && (cand_bcid == last_bcid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_vld  <= 1'b0;
            last_band <= '0;
            last_bcid <= '0;
        end else if (flush) begin
            last_vld <= 1'b0;
        end else if (push_ok) begin
            last_vld  <= 1'b1;
            last_band <= cand_band_id;
            last_bcid <= cand_bcid;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // The head entry leaves the FIFO at the end of the ISSUE cycle.
    assign pop     = (state == ST_ISSUE);
    assign push_ok = cand_valid && !flush && !dup && (!fifo_full || pop);
    assign drop    = cand_valid && !flush && !dup && fifo_full && !pop;
    assign remain  = (fifo_level > LVL_W'(1)) || push_ok;

    // Flush suppresses the strobe within its own cycle, not just from the next edge.
    assign load_out = load_q && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot <= 2'd0;
        end else begin
            slot <= slot + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            load_q      <= 1'b0;
            band_id_out <= '0;
            bcid_out    <= '0;
        end else if (flush) begin
            state  <= ST_IDLE;
            load_q <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if ((slot == ISSUE_SLOT) && gen_ready) begin
                        state       <= ST_ISSUE;
                        load_q      <= 1'b1;
                        band_id_out <= head_band;
                        bcid_out    <= head_bcid;
                    end
                end
                ST_ISSUE: begin
                    state <= remain ? ST_ARMED : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_band_trigger_scheduler.sv
// Self-checking bench for band_trigger_scheduler: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_band_trigger_scheduler;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cand_valid = 1'b0;
    logic [7:0]  cand_band_id = '0;
    logic [11:0] cand_bcid = '0;
    logic        gen_ready = 1'b0;
    logic        flush = 1'b0;
    logic        load_out;
    logic [7:0]  band_id_out;
    logic [11:0] bcid_out;
    logic [3:0]  fifo_level;
    logic [7:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    band_trigger_scheduler #(.DEPTH(DEPTH), .BCID_W(12), .BAND_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cand_valid   (cand_valid),
        .cand_band_id (cand_band_id),
        .cand_bcid    (cand_bcid),
        .gen_ready    (gen_ready),
        .flush        (flush),
        .load_out     (load_out),
        .band_id_out  (band_id_out),
        .bcid_out     (bcid_out),
        .fifo_level   (fifo_level),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cand_valid = 1'b0;
        flush      = 1'b0;
    endtask

    // Leaves the bench at the start of the first post-reset cycle (slot 0).
    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        gen_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic push_one(input logic [7:0] b, input logic [11:0] c);
        cand_valid   = 1'b1;
        cand_band_id = b;
        cand_bcid    = c;
        @(negedge clk);
        next_cycle();
        cand_valid = 1'b0;
    endtask

    // Returns at the negedge of the strobe cycle (waited = cycles before it) or -1.
    task automatic wait_load(input int limit, output int waited);
        waited = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (load_out) begin
                waited = k;
                return;
            end
            next_cycle();
        end
        @(negedge clk);
    endtask

    task automatic count_loads(input int n, output int cnt, output int last_bcid);
        cnt = 0;
        last_bcid = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (load_out) begin
                cnt++;
                last_bcid = int'(bcid_out);
            end
            next_cycle();
        end
    endtask

    // ---------------- reference model ----------------
    logic [19:0] mq[$];
    int          m_drop, m_slot, m_lvl_d1, m_lvl_d2;
    bit          m_gr_d1, m_fl_d1, m_fl_d2, m_iss;
    bit          m_last_vld;
    logic [19:0] m_last;
    logic [7:0]  m_band;
    logic [11:0] m_bcid;

    task automatic m_reset();
        mq.delete();
        m_drop = 0; m_slot = 0; m_lvl_d1 = 0; m_lvl_d2 = 0;
        m_gr_d1 = 0; m_fl_d1 = 0; m_fl_d2 = 0; m_iss = 0;
        m_last_vld = 0; m_last = '0; m_band = '0; m_bcid = '0;
    endtask

    // A strobe lands in slot 0 when the queue held entries two cycles earlier,
    // gen_ready was high in the preceding slot 3 and no flush intervened.
    task automatic m_eval();
        m_iss = (m_slot == 0) && m_gr_d1 && !m_fl_d1 && !m_fl_d2 && (m_lvl_d2 > 0);
        if (m_iss) {m_band, m_bcid} = mq[0];
    endtask

    task automatic m_edge();
        bit full, dupl;
        m_lvl_d2 = m_lvl_d1;
        m_lvl_d1 = mq.size();
        m_fl_d2  = m_fl_d1;
        m_fl_d1  = flush;
        m_gr_d1  = gen_ready;
        m_slot   = (m_slot + 1) % 4;
        if (flush) begin
            mq.delete();
            m_last_vld = 0;
        end else begin
            full = (mq.size() == DEPTH);
            if (m_iss) void'(mq.pop_front());
`ifdef BTS_DEDUP_EN
            dupl = m_last_vld && (m_last == {cand_band_id, cand_bcid});
`else
            dupl = 0;
`endif
            if (cand_valid && !dupl) begin
                if (!full || m_iss) begin
                    mq.push_back({cand_band_id, cand_bcid});
                    m_last = {cand_band_id, cand_bcid};
                    m_last_vld = 1;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end
    endtask

    typedef struct {
        logic        cv;
        logic [7:0]  band;
        logic [11:0] bcid;
        logic        gr;
        logic        fl;
        logic        e_load;
        logic [7:0]  e_band;
        logic [11:0] e_bcid;
        int          e_level;
        int          e_drop;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int w, cnt, lastb, gr_pct;

        tbl[0]  = '{1'b1, 8'h2A, 12'h123, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000, 0, 0};
        tbl[1]  = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000, 1, 0};
        tbl[2]  = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000, 1, 0};
        tbl[3]  = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000, 1, 0};
        tbl[4]  = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b1, 8'h2A, 12'h123, 1, 0};
        tbl[5]  = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 8'h2A, 12'h123, 0, 0};
        tbl[6]  = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 8'h2A, 12'h123, 0, 0};
        tbl[7]  = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 8'h2A, 12'h123, 0, 0};
        tbl[8]  = '{1'b1, 8'h31, 12'h031, 1'b0, 1'b0, 1'b0, 8'h2A, 12'h123, 0, 0};
        tbl[9]  = '{1'b1, 8'h32, 12'h032, 1'b0, 1'b0, 1'b0, 8'h2A, 12'h123, 1, 0};
        tbl[10] = '{1'b1, 8'h33, 12'h033, 1'b0, 1'b1, 1'b0, 8'h2A, 12'h123, 2, 0};
        tbl[11] = '{1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 8'h2A, 12'h123, 0, 0};
        tbl[12] = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 8'h2A, 12'h123, 0, 0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.load", int'(load_out), 0);
        chk("rst.band", int'(band_id_out), 0);
        chk("rst.bcid", int'(bcid_out), 0);
        chk("rst.level", int'(fifo_level), 0);
        chk("rst.drop", int'(drop_cnt), 0);

        // Vector table: single candidate issue, then a flush with pending entries
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cand_valid   = tbl[i].cv;
            cand_band_id = tbl[i].band;
            cand_bcid    = tbl[i].bcid;
            gen_ready    = tbl[i].gr;
            flush        = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("vec%0d.load", i), int'(load_out), int'(tbl[i].e_load));
            chk($sformatf("vec%0d.band", i), int'(band_id_out), int'(tbl[i].e_band));
            chk($sformatf("vec%0d.bcid", i), int'(bcid_out), int'(tbl[i].e_bcid));
            chk($sformatf("vec%0d.level", i), int'(fifo_level), tbl[i].e_level);
            chk($sformatf("vec%0d.drop", i), int'(drop_cnt), tbl[i].e_drop);
            next_cycle();
        end
        idle_inputs();

        // Nine candidates into an 8-deep FIFO, then drain in order at 4-cycle spacing
        do_reset();
        for (int i = 0; i < 9; i++) push_one(8'(8'h10 + i), 12'(12'h200 + i));
        @(negedge clk);
        chk("fill9.level", int'(fifo_level), 8);
        chk("fill9.drop", int'(drop_cnt), 1);
        next_cycle();
        gen_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_load(8, w);
            chk($sformatf("drain%0d.seen", k), int'(w >= 0), 1);
            if (k > 0) chk($sformatf("drain%0d.spacing", k), w + 1, 4);
            chk($sformatf("drain%0d.band", k), int'(band_id_out), 'h10 + k);
            chk($sformatf("drain%0d.bcid", k), int'(bcid_out), 'h200 + k);
            next_cycle();
        end
        count_loads(10, cnt, lastb);
        chk("drain.extra", cnt, 0);
        @(negedge clk);
        chk("drain.level", int'(fifo_level), 0);
        next_cycle();

        // Full FIFO: candidate arriving in the issue cycle is accepted
        do_reset();
        for (int i = 0; i < 8; i++) push_one(8'(8'h40 + i), 12'(12'h300 + i));
        gen_ready = 1'b1;
        wait_load(8, w);
        chk("fullpop.seen", int'(w >= 0), 1);
        chk("fullpop.band", int'(band_id_out), 'h40);
        cand_valid = 1'b1; cand_band_id = 8'hAA; cand_bcid = 12'h3AA;
        next_cycle();
        cand_valid = 1'b0;
        @(negedge clk);
        chk("fullpop.level", int'(fifo_level), 8);
        chk("fullpop.drop", int'(drop_cnt), 0);
        next_cycle();
        for (int k = 1; k < 9; k++) begin
            wait_load(8, w);
            chk($sformatf("fullpop%0d.seen", k), int'(w >= 0), 1);
            chk($sformatf("fullpop%0d.band", k), int'(band_id_out), (k < 8) ? ('h40 + k) : 'hAA);
            next_cycle();
        end

        // Flush with three entries plus a same-cycle candidate, then flush mid-issue
        do_reset();
        for (int i = 0; i < 3; i++) push_one(8'(8'h50 + i), 12'(12'h050 + i));
        flush = 1'b1; cand_valid = 1'b1; cand_band_id = 8'h77; cand_bcid = 12'h077;
        @(negedge clk);
        chk("flush.load", int'(load_out), 0);
        chk("flush.level_before", int'(fifo_level), 3);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("flush.level", int'(fifo_level), 0);
        chk("flush.drop", int'(drop_cnt), 0);
        next_cycle();
        gen_ready = 1'b1;
        count_loads(12, cnt, lastb);
        chk("flush.no_load", cnt, 0);
        push_one(8'h58, 12'h058);
        wait_load(12, w);
        chk("flushiss.seen", int'(w >= 0), 1);
        flush = 1'b1;
        #1;
        chk("flushiss.load", int'(load_out), 0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("flushiss.level", int'(fifo_level), 0);
        next_cycle();

        // Duplicate candidates
        do_reset();
        gen_ready = 1'b1;
        push_one(8'h05, 12'h0FF);
        push_one(8'h05, 12'h0FF);
        push_one(8'h05, 12'h100);
        count_loads(24, cnt, lastb);
`ifdef BTS_DEDUP_EN
        chk("dedup.strobes", cnt, 2);
`else
        chk("dedup.strobes", cnt, 3);
`endif
        chk("dedup.last_bcid", lastb, 'h100);
        chk("dedup.drop", int'(drop_cnt), 0);

        // Reset asserted during the issue cycle
        do_reset();
        gen_ready = 1'b1;
        push_one(8'h66, 12'h066);
        wait_load(12, w);
        chk("rstiss.seen", int'(w >= 0), 1);
        reset_n = 1'b0;
        #1;
        chk("rstiss.load", int'(load_out), 0);
        chk("rstiss.band", int'(band_id_out), 0);
        chk("rstiss.bcid", int'(bcid_out), 0);
        chk("rstiss.level", int'(fifo_level), 0);
        chk("rstiss.drop", int'(drop_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        count_loads(16, cnt, lastb);
        chk("rstiss.no_load", cnt, 0);
        push_one(8'h67, 12'h067);
        wait_load(12, w);
        chk("rstiss.new_seen", int'(w >= 0), 1);
        chk("rstiss.new_band", int'(band_id_out), 'h67);
        next_cycle();

        // drop_cnt saturation
        do_reset();
        cand_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cand_band_id = 8'h01;
            cand_bcid    = 12'(i);
            next_cycle();
        end
        cand_valid = 1'b0;
        @(negedge clk);
        chk("sat.drop", int'(drop_cnt), 255);
        chk("sat.level", int'(fifo_level), 8);
        next_cycle();

        // Randomized run against the reference model
        do_reset();
        m_reset();
        gr_pct = 90;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 64 == 0) gr_pct = ($urandom_range(0, 1) != 0) ? 90 : 10;
            cand_valid   = ($urandom_range(0, 99) < 60);
            cand_band_id = 8'($urandom_range(0, 3));
            cand_bcid    = 12'($urandom_range(0, 3));
            gen_ready    = ($urandom_range(0, 99) < gr_pct);
            flush        = ($urandom_range(0, 99) < 2);
            m_eval();
            @(negedge clk);
            chk("rnd.load", int'(load_out), int'(m_iss && !flush));
            chk("rnd.band", int'(band_id_out), int'(m_band));
            chk("rnd.bcid", int'(bcid_out), int'(m_bcid));
            chk("rnd.level", int'(fifo_level), mq.size());
            chk("rnd.drop", int'(drop_cnt), m_drop);
            m_edge();
            next_cycle();
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
